ocx_tlx_xmt_credit_arb: RTL and testbench
=========================================

Name: ocx_tlx_xmt_credit_arb

Overview:
- Transmit-side credit scheduler for the TLX. Tracks the TL-granted VC0/VC3 command credits and DCP0/DCP3 data credits delivered on the rcv_xmt_credit_* return interface.
- Arbitrates the response requester (VC0/DCP0) against the command requester (VC3/DCP3) for one transmit slot per cycle.
- Debits credits at grant. Sits between the TLX credit-return decode and the framer's command/response issue logic.

Parameters:
- VC_CW, 8, width of each VC credit counter.
- DCP_CW, 8, width of each DCP credit counter.
- STARVE_MAX, 8, consecutive response wins over an eligible, pending command before that command is forced to win (range 1..255).

Ports:
- tlx_clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- arb_enable  in  1  1 = grants allowed; 0 = no grants, credit accounting continues
- rcv_xmt_credit_tlx_v  in  1  credit-return valid pulse
- rcv_xmt_credit_vcx0  in  4  VC0 credits returned
- rcv_xmt_credit_vcx3  in  4  VC3 credits returned
- rcv_xmt_credit_dcpx0  in  6  DCP0 credits returned
- rcv_xmt_credit_dcpx3  in  6  DCP3 credits returned
- rsp_req  in  1  response request; held until rsp_gnt
- rsp_dcnt  in  2  response data size: 00=0, 01=1, 10=2, 11=4 flits
- cmd_req  in  1  command request; held until cmd_gnt
- cmd_dcnt  in  2  command data size, same encoding
- rsp_gnt  out  1  response granted this cycle (combinational)
- cmd_gnt  out  1  command granted this cycle (combinational)
- vc0_credits  out  VC_CW  current VC0 count
- vc3_credits  out  VC_CW  current VC3 count
- dcp0_credits  out  DCP_CW  current DCP0 count
- dcp3_credits  out  DCP_CW  current DCP3 count
- credit_ovf_err  out  1  sticky overflow error

Behaviour:
- Reset, while reset_n=0 at a clock edge:
  - all counters = 0, starve counter = 0, credit_ovf_err = 0.
  - rsp_gnt and cmd_gnt are forced 0 during reset.
  - Initial credits arrive only through the first return pulse.
- Flit count f(dcnt): 00→0, 01→1, 10→2, 11→4.
- Eligibility, from registered counters only (a return arriving this cycle is usable next cycle):
  - rsp_elig = rsp_req & (vc0 ≥ 1) & (dcp0 ≥ f(rsp_dcnt)).
  - cmd_elig = cmd_req & (vc3 ≥ 1) & (dcp3 ≥ f(cmd_dcnt)).
- Grant, combinational, at most one per cycle, only when arb_enable=1:
  - only one side eligible → that side granted.
  - both eligible → rsp wins, unless starve counter = STARVE_MAX, in which case cmd wins.
- Handshake:
  - valid/ready. The request is consumed in the cycle gnt=1.
  - The requester may present a new request (new dcnt) in the next cycle.
  - dcnt must be stable while req=1 and gnt=0.
- Starve counter:
  - +1 on each cycle where both are eligible and rsp wins.
  - cleared on any cmd_gnt.
  - held otherwise, including cycles where cmd is not eligible.
  - never exceeds STARVE_MAX.
- Counter update per edge, per counter: next = cnt + ret − debit.
  - ret applies only when rcv_xmt_credit_tlx_v=1.
  - Granted side's debit: VC by 1, DCP by f(dcnt).
  - Computed at VC_CW+1 / DCP_CW+1 bits. Return and debit in the same cycle are both applied.
  - If the result exceeds 2^W−1: saturate at 2^W−1 and set credit_ovf_err, which stays set until reset.
  - Underflow cannot occur, because of eligibility gating.
- arb_enable=0: returns are still accumulated and the starve counter is held.
- Reset mid-operation: all counts are discarded; credits must be re-delivered.

Test Plan:
1. Reset, then return pulse vcx0=4, vcx3=2, dcpx0=8, dcpx3=6 → next cycle counts read 4/2/8/6, no grants, err=0.
2. From (1), rsp_req with dcnt=11 → rsp_gnt=1 the same cycle; next cycle vc0=3, dcp0=4. Repeat → vc0=2, dcp0=0. Third request with dcnt=01 is held with gnt=0 until a return of dcpx0=1, then granted one cycle after the return.
3. Both requesters eligible every cycle with ample credits, STARVE_MAX=8 → 8 rsp grants, then 1 cmd grant, repeating; never two grants in one cycle.
4. vc3=1, dcp3=2, cmd_req dcnt=10 granted in the same cycle as a return of vcx3=3, dcpx3=5 → next cycle vc3=3, dcp3=5.
5. VC_CW=8 with vc0=250, return vcx0=15 → vc0=255, credit_ovf_err=1; err stays 1 after later grants until reset_n=0.
6. arb_enable=0 with both requests pending and credits available → no grants, returns still accumulate; raise arb_enable → rsp granted that cycle.

Source files
------------

// File: rtl/ocx_tlx_xmt_credit_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_xmt_credit_arb_if
// Description : Credit-return, request/grant and credit-status bundle for
//               the TLX transmit credit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ocx_tlx_xmt_credit_arb_if #(
  parameter int VC_CW  = 8,
  parameter int DCP_CW = 8
);
  logic              arb_enable;
  logic              rcv_xmt_credit_tlx_v;
  logic [3:0]        rcv_xmt_credit_vcx0;
  logic [3:0]        rcv_xmt_credit_vcx3;
  logic [5:0]        rcv_xmt_credit_dcpx0;
  logic [5:0]        rcv_xmt_credit_dcpx3;
  logic              rsp_req;
  logic [1:0]        rsp_dcnt;
  logic              cmd_req;
  logic [1:0]        cmd_dcnt;
  logic              rsp_gnt;
  logic              cmd_gnt;
  logic [VC_CW-1:0]  vc0_credits;
  logic [VC_CW-1:0]  vc3_credits;
  logic [DCP_CW-1:0] dcp0_credits;
  logic [DCP_CW-1:0] dcp3_credits;
  logic              credit_ovf_err;

  modport master (
    output arb_enable, rcv_xmt_credit_tlx_v, rcv_xmt_credit_vcx0,
           rcv_xmt_credit_vcx3, rcv_xmt_credit_dcpx0, rcv_xmt_credit_dcpx3,
           rsp_req, rsp_dcnt, cmd_req, cmd_dcnt,
    input  rsp_gnt, cmd_gnt, vc0_credits, vc3_credits, dcp0_credits,
           dcp3_credits, credit_ovf_err
  );

  modport slave (
    input  arb_enable, rcv_xmt_credit_tlx_v, rcv_xmt_credit_vcx0,
           rcv_xmt_credit_vcx3, rcv_xmt_credit_dcpx0, rcv_xmt_credit_dcpx3,
           rsp_req, rsp_dcnt, cmd_req, cmd_dcnt,
    output rsp_gnt, cmd_gnt, vc0_credits, vc3_credits, dcp0_credits,
           dcp3_credits, credit_ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/ocx_tlx_xmt_credit_arb.sv
`default_nettype none
// ============================================================================
// Module      : ocx_tlx_xmt_credit_arb
// Description : TLX transmit credit tracker and response/command arbiter
//               with starvation guard and saturating credit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ocx_tlx_xmt_credit_arb #(
  parameter int VC_CW      = 8,
  parameter int DCP_CW     = 8,
  parameter int STARVE_MAX = 8
) (
  input wire logic                 tlx_clk,
  input wire logic                 reset_n,
  ocx_tlx_xmt_credit_arb_if.slave  bus
);

  function automatic logic [2:0] flits(input logic [1:0] dcnt);
    case (dcnt)
      2'b00:   flits = 3'd0;
      2'b01:   flits = 3'd1;
      2'b10:   flits = 3'd2;
      default: flits = 3'd4;
    endcase
  endfunction

  logic [VC_CW-1:0]  r_vc0;
  logic [VC_CW-1:0]  r_vc3;
  logic [DCP_CW-1:0] r_dcp0;
  logic [DCP_CW-1:0] r_dcp3;
  logic [7:0]        r_starve;
  logic              r_ovf;

  logic [2:0]        w_rsp_flits;
  logic [2:0]        w_cmd_flits;
  logic              w_rsp_elig;
  logic              w_cmd_elig;
  logic              w_starve_max;
  logic              w_rsp_gnt;
  logic              w_cmd_gnt;
  logic              w_rv;
  logic [VC_CW:0]    w_vc0_sum;
  logic [VC_CW:0]    w_vc3_sum;
  logic [DCP_CW:0]   w_dcp0_sum;
  logic [DCP_CW:0]   w_dcp3_sum;

  assign w_rsp_flits = flits(bus.rsp_dcnt);
  assign w_cmd_flits = flits(bus.cmd_dcnt);

  // Eligibility uses registered counts only; same-cycle returns are not visible.
  assign w_rsp_elig = bus.rsp_req & (r_vc0 != '0) & (DCP_CW'(w_rsp_flits) <= r_dcp0);
  assign w_cmd_elig = bus.cmd_req & (r_vc3 != '0) & (DCP_CW'(w_cmd_flits) <= r_dcp3);
  assign w_starve_max = (r_starve == 8'(STARVE_MAX));

  assign w_rsp_gnt = reset_n & bus.arb_enable & w_rsp_elig & ~(w_cmd_elig & w_starve_max);
  assign w_cmd_gnt = reset_n & bus.arb_enable & w_cmd_elig & (~w_rsp_elig | w_starve_max);

  assign w_rv = bus.rcv_xmt_credit_tlx_v;

  // One extra bit catches overflow; debit never exceeds the count, so no wrap below zero.
  assign w_vc0_sum  = {1'b0, r_vc0} + (w_rv ? (VC_CW+1)'(bus.rcv_xmt_credit_vcx0) : '0)
                      - (VC_CW+1)'(w_rsp_gnt);
  assign w_vc3_sum  = {1'b0, r_vc3} + (w_rv ? (VC_CW+1)'(bus.rcv_xmt_credit_vcx3) : '0)
                      - (VC_CW+1)'(w_cmd_gnt);
  assign w_dcp0_sum = {1'b0, r_dcp0} + (w_rv ? (DCP_CW+1)'(bus.rcv_xmt_credit_dcpx0) : '0)
                      - (w_rsp_gnt ? (DCP_CW+1)'(w_rsp_flits) : '0);
  assign w_dcp3_sum = {1'b0, r_dcp3} + (w_rv ? (DCP_CW+1)'(bus.rcv_xmt_credit_dcpx3) : '0)
                      - (w_cmd_gnt ? (DCP_CW+1)'(w_cmd_flits) : '0);

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      r_vc0    <= '0;
      r_vc3    <= '0;
      r_dcp0   <= '0;
      r_dcp3   <= '0;
      r_starve <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_vc0  <= w_vc0_sum[VC_CW]   ? '1 : w_vc0_sum[VC_CW-1:0];
      r_vc3  <= w_vc3_sum[VC_CW]   ? '1 : w_vc3_sum[VC_CW-1:0];
      r_dcp0 <= w_dcp0_sum[DCP_CW] ? '1 : w_dcp0_sum[DCP_CW-1:0];
      r_dcp3 <= w_dcp3_sum[DCP_CW] ? '1 : w_dcp3_sum[DCP_CW-1:0];
      r_ovf  <= r_ovf | w_vc0_sum[VC_CW] | w_vc3_sum[VC_CW]
                      | w_dcp0_sum[DCP_CW] | w_dcp3_sum[DCP_CW];
      if (w_cmd_gnt) begin
        r_starve <= '0;
      end else if (w_rsp_gnt && w_cmd_elig && !w_starve_max) begin
        r_starve <= r_starve + 8'd1;
      end
    end
  end

  assign bus.rsp_gnt        = w_rsp_gnt;
  assign bus.cmd_gnt        = w_cmd_gnt;
  assign bus.vc0_credits    = r_vc0;
  assign bus.vc3_credits    = r_vc3;
  assign bus.dcp0_credits   = r_dcp0;
  assign bus.dcp3_credits   = r_dcp3;
  assign bus.credit_ovf_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ocx_tlx_xmt_credit_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ocx_tlx_xmt_credit_arb
// Description : Directed scoreboard bench for the TLX transmit credit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocx_tlx_xmt_credit_arb;
  localparam int VC_CW      = 8;
  localparam int DCP_CW     = 8;
  localparam int STARVE_MAX = 8;

  logic tlx_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_xmt_credit_arb_if #(.VC_CW(VC_CW), .DCP_CW(DCP_CW)) bus ();

  ocx_tlx_xmt_credit_arb #(.VC_CW(VC_CW), .DCP_CW(DCP_CW), .STARVE_MAX(STARVE_MAX)) dut (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic       rg;
    logic       cg;
    logic       chk;
    logic [7:0] v0;
    logic [7:0] v3;
    logic [7:0] d0;
    logic [7:0] d3;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge tlx_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rsp_gnt", 32'(bus.rsp_gnt), 32'(e.rg));
        check("cmd_gnt", 32'(bus.cmd_gnt), 32'(e.cg));
        check("onehot",  32'(bus.rsp_gnt & bus.cmd_gnt), 32'd0);
        if (e.chk) begin
          check("vc0",  32'(bus.vc0_credits),    32'(e.v0));
          check("vc3",  32'(bus.vc3_credits),    32'(e.v3));
          check("dcp0", 32'(bus.dcp0_credits),   32'(e.d0));
          check("dcp3", 32'(bus.dcp3_credits),   32'(e.d3));
          check("err",  32'(bus.credit_ovf_err), 32'(e.err));
        end
      end
    end
  end

  task automatic idle();
    bus.arb_enable           = 1'b1;
    bus.rcv_xmt_credit_tlx_v = 1'b0;
    bus.rcv_xmt_credit_vcx0  = '0;
    bus.rcv_xmt_credit_vcx3  = '0;
    bus.rcv_xmt_credit_dcpx0 = '0;
    bus.rcv_xmt_credit_dcpx3 = '0;
    bus.rsp_req              = 1'b0;
    bus.rsp_dcnt             = '0;
    bus.cmd_req              = 1'b0;
    bus.cmd_dcnt             = '0;
  endtask

  task automatic ret(input logic [3:0] r0, input logic [3:0] r3,
                     input logic [5:0] d0, input logic [5:0] d3);
    bus.rcv_xmt_credit_tlx_v = 1'b1;
    bus.rcv_xmt_credit_vcx0  = r0;
    bus.rcv_xmt_credit_vcx3  = r3;
    bus.rcv_xmt_credit_dcpx0 = d0;
    bus.rcv_xmt_credit_dcpx3 = d3;
  endtask

  task automatic rsp(input logic [1:0] d);
    bus.rsp_req  = 1'b1;
    bus.rsp_dcnt = d;
  endtask

  task automatic cmd(input logic [1:0] d);
    bus.cmd_req  = 1'b1;
    bus.cmd_dcnt = d;
  endtask

  task automatic cyc(input logic rg, input logic cg);
    exp_t e;
    e = '{rg: rg, cg: cg, chk: 1'b0, v0: 8'd0, v3: 8'd0, d0: 8'd0, d3: 8'd0, err: 1'b0};
    q.push_back(e);
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic cycc(input logic rg, input logic cg, input logic [7:0] v0, input logic [7:0] v3,
                      input logic [7:0] d0, input logic [7:0] d3, input logic err);
    exp_t e;
    e = '{rg: rg, cg: cg, chk: 1'b1, v0: v0, v3: v3, d0: d0, d3: d3, err: err};
    q.push_back(e);
    @(posedge tlx_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    @(posedge tlx_clk);
    #1;
    // Reset with requests pending: grants forced low.
    reset_n = 1'b0; rsp(2'b00); cmd(2'b00);
    cyc(0, 0);
    cyc(0, 0);
    reset_n = 1'b1; idle();
    cycc(0, 0, 0, 0, 0, 0, 0);

    // Initial credit delivery.
    idle(); ret(4, 2, 8, 6);  cycc(0, 0, 0, 0, 0, 0, 0);
    idle();                   cycc(0, 0, 4, 2, 8, 6, 0);

    // Response debits and hold on insufficient DCP0.
    idle(); rsp(2'b11);       cycc(1, 0, 4, 2, 8, 6, 0);
    idle(); rsp(2'b11);       cycc(1, 0, 3, 2, 4, 6, 0);
    idle(); rsp(2'b01);       cycc(0, 0, 2, 2, 0, 6, 0);
    idle(); rsp(2'b01); ret(0, 0, 1, 0); cycc(0, 0, 2, 2, 0, 6, 0);
    idle(); rsp(2'b01);       cycc(1, 0, 2, 2, 1, 6, 0);
    idle();                   cycc(0, 0, 1, 2, 0, 6, 0);

    // Command grant concurrent with a return.
    idle(); cmd(2'b11);       cycc(0, 1, 1, 2, 0, 6, 0);
    idle(); cmd(2'b10); ret(0, 3, 0, 5); cycc(0, 1, 1, 1, 0, 2, 0);
    idle();                   cycc(0, 0, 1, 3, 0, 5, 0);

    // Arbitration disabled: returns accumulate, no grants.
    idle(); bus.arb_enable = 1'b0; rsp(2'b00); cmd(2'b00); ret(2, 0, 0, 0);
    cycc(0, 0, 1, 3, 0, 5, 0);
    idle(); bus.arb_enable = 1'b0; rsp(2'b00); cmd(2'b00);
    cycc(0, 0, 3, 3, 0, 5, 0);
    idle(); rsp(2'b00); cmd(2'b00); cycc(1, 0, 3, 3, 0, 5, 0);
    idle(); cmd(2'b00);       cycc(0, 1, 2, 3, 0, 5, 0);
    idle();                   cycc(0, 0, 2, 2, 0, 5, 0);

    // Starvation guard: 8 response wins then 1 command win.
    idle(); ret(15, 15, 0, 0); cyc(0, 0);
    idle(); ret(15, 15, 0, 0); cyc(0, 0);
    for (int i = 0; i < 27; i++) begin
      idle(); rsp(2'b00); cmd(2'b00);
      if ((i % 9) == 8) cyc(0, 1);
      else              cyc(1, 0);
    end
    idle();                   cycc(0, 0, 8, 29, 0, 5, 0);

    // Overflow saturation and sticky error.
    for (int i = 0; i < 16; i++) begin
      idle(); ret(15, 0, 0, 0); cyc(0, 0);
    end
    idle(); ret(2, 0, 0, 0);  cyc(0, 0);
    idle();                   cycc(0, 0, 250, 29, 0, 5, 0);
    idle(); ret(15, 0, 0, 0); cycc(0, 0, 250, 29, 0, 5, 0);
    idle();                   cycc(0, 0, 255, 29, 0, 5, 1);
    idle(); rsp(2'b00);       cycc(1, 0, 255, 29, 0, 5, 1);
    idle();                   cycc(0, 0, 254, 29, 0, 5, 1);

    // Mid-operation reset discards everything.
    reset_n = 1'b0; rsp(2'b00); cyc(0, 0);
    reset_n = 1'b1; idle();   cycc(0, 0, 0, 0, 0, 0, 0);
    idle(); rsp(2'b00);       cycc(0, 0, 0, 0, 0, 0, 0);

    idle();
    @(negedge tlx_clk);
    @(negedge tlx_clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
`default_nettype wire
